paillier_mont_cmd_seq: RTL
==========================

// Module: paillier_mont_cmd_seq
// PURPOSE
// Command sequencer upstream of montgomery_iddmm_top. Accepts one ME or MM command plus a 2N-word operand stream.
// Drives the engine's me_*/mm_* load ports, and captures the N-word result in an N-deep buffer.
// Replays the result as a back-pressured stream. One command in flight; the me/mm paths are never active together.
// PARAMETERS
// K   256  bits per word (must match engine K)
// N   16   words per operand / result (must match engine N); power of two, >=2
// PORTS
// clk          in   1   clock
// rst_n        in   1   reset; asynchronous, active-low
// cmd_valid    in   1   command request
// cmd_ready    out  1   command accepted when cmd_valid&&cmd_ready
// cmd_op       in   1   0=modular exponentiation (me_*), 1=modular multiply (mm_*)
// cmd_mm_type  in   2   mm_type for op=1, latched at accept
// s_data       in   K   operand word; N words of x then N words of y, low word first
// s_valid      in   1   operand word valid
// s_ready      out  1   operand word taken when s_valid&&s_ready
// m_data       out  K   result word, low word first
// m_valid      out  1   result word valid
// m_ready      in   1   downstream accepts result word
// m_last       out  1   marks Nth result word
// busy         out  1   state!=IDLE
// err_unexp    out  1   sticky: me_valid/mm_valid seen outside WAIT_RES; cleared only by reset
// me_start, me_x, me_x_valid, me_y, me_y_valid  out  1,K,1,K,1  engine ME load port
// me_result, me_valid                           in   K,1        engine ME result, one word per me_valid
// mm_type, mm_start, mm_x, mm_x_valid, mm_y, mm_y_valid  out 2,1,K,1,K,1  engine MM load port
// mm_result, mm_valid                           in   K,1        engine MM result
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0 except cmd_ready=1. Word counters, buffer pointers and op_q are 0; err_unexp=0.
// - FSM IDLE -> START -> LOAD_X -> LOAD_Y -> WAIT_RES -> IDLE.
// - IDLE: cmd_ready=1; on accept, latch op_q and mm_type_q, then go to START.
// - START: exactly one-cycle pulse on me_start (op_q=0) or mm_start (op_q=1). Then LOAD_X.
// - LOAD_X/LOAD_Y: s_ready=1. Each transfer is forwarded combinationally.
//   - The selected *_x (or *_y) bus equals s_data; the selected *_x_valid (or *_y_valid) = s_valid.
//   - Unselected path valids are 0; unselected data buses are held 0.
//   - wcnt counts transfers; at wcnt==N-1 with a transfer, wcnt wraps to 0 and the state advances.
//   - s_valid gaps are allowed; the engine never back-pressures.
// - WAIT_RES: sample mm_valid?mm_result:me_result per op_q into buffer[wptr]; rcnt++.
//   - Draining runs concurrently: m_valid = (count!=0).
//   - Pop on m_valid&&m_ready; m_last=1 when the pop index == N-1 of this command.
//   - Exit to IDLE when rcnt==N and the last word has popped (same cycle allowed).
//   - Buffer depth N, so overflow is impossible.
//   - A push and a pop in the same cycle leave count unchanged.
// - mm_type output = mm_type_q, held stable from START until return to IDLE.
// - Result valid of the non-selected path, or any result valid outside WAIT_RES, sets err_unexp.
//   That word is dropped.
// - Result valid during START/LOAD_* is also an error and is dropped.
// - cmd_valid while busy: ignored (cmd_ready=0). Command is not lost; the requester holds it.
// - Reset mid-operation: immediate return to IDLE; buffer contents discarded; no start pulse is re-issued.
// - Latency: first me_x_valid no earlier than 2 cycles after command accept.
//   m_valid asserts 1 cycle after the first result word is sampled (registered buffer).
// STRUCTURE
// - Package paillier_seq_pkg: typedef enum logic [2:0] {IDLE,START,LOAD_X,LOAD_Y,WAIT_RES} seq_state_e;
//   localparam OP_ME=1'b0, OP_MM=1'b1.
// - Sub-module paillier_res_buf: N x K synchronous-write buffer with wptr/rptr ($clog2(N)+1 bits),
//   count, push/pop, and a registered read port.
// - Top instantiates paillier_res_buf; the FSM plus load mux live in the top.
// TESTING
// - ME basic, N=4: cmd op=0; x=1,2,3,4; y=5,6,7,8 back-to-back.
//   -> one me_start pulse; me_x_valid 4 cycles; then me_y_valid 4 cycles; mm_* all 0.
//   -> model returns 9..12 -> m_data 9,10,11,12 with m_last on 12; busy drops after.
// - MM type 2: cmd op=1, mm_type=2; operands with random s_valid gaps.
//   -> mm_start once; mm_type=2 stable throughout; words forwarded only on s_valid; me_* idle.
// - Backpressure: m_ready=0 until all N results are buffered, then 1.
//   -> no words lost; order 0..N-1; state stays WAIT_RES until the last pop.
// - Simultaneous push/pop: m_ready=1 while results stream each cycle.
//   -> count never exceeds 1; m_data equals result delayed 1 cycle.
// - Error: me_valid pulsed in IDLE -> err_unexp=1 sticky; no m_valid.
//   Also mm_valid during an ME command -> err_unexp=1.
// - Reset mid-LOAD_Y (after 2 y words) -> all outputs at reset values, cmd_ready=1.
//   -> a new ME command afterwards completes normally.

Source files
------------

// File: rtl/paillier_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : paillier_seq_pkg
// Description : Shared state encoding and opcode constants for the Paillier
//               Montgomery command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package paillier_seq_pkg;

  // Sequencer states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    LOAD_X   = 3'd2,
    LOAD_Y   = 3'd3,
    WAIT_RES = 3'd4
  } seq_state_e;

  // Command opcodes
  localparam logic OP_ME = 1'b0;
  localparam logic OP_MM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/paillier_res_buf.sv
`default_nettype none
// ============================================================================
// Module      : paillier_res_buf
// Description : N x K result FIFO with synchronous write and a registered read
//               port. The read register always holds the word at the head of
//               the queue for the next cycle, with write-forwarding when the
//               word being pushed becomes the head.
// Revision    : 1.0 - initial release
// ============================================================================
module paillier_res_buf #(
  parameter int K = 256,
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [K-1:0]         push_data,
  input  logic                 pop,
  output logic [K-1:0]         rd_data,
  output logic [$clog2(N)-1:0] rd_idx,
  output logic [$clog2(N):0]   count
);

  localparam int AW = $clog2(N);
  localparam int PW = AW + 1;

  logic [K-1:0]  r_mem [N];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_count;
  logic [K-1:0]  r_rd_data;
  logic [AW-1:0] w_head_nxt;

  // Head slot after this cycle's pop
  assign w_head_nxt = pop ? (r_rptr[AW-1:0] + AW'(1)) : r_rptr[AW-1:0];

  assign rd_data = r_rd_data;
  assign rd_idx  = r_rptr[AW-1:0];
  assign count   = r_count;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wptr[AW-1:0]] <= push_data;
    end
  end

  // Pointers, occupancy and registered head word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + PW'(1);
      if (pop)  r_rptr <= r_rptr + PW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase
      // A push landing in the next head slot must bypass the array
      if (push && (r_wptr[AW-1:0] == w_head_nxt)) begin
        r_rd_data <= push_data;
      end else begin
        r_rd_data <= r_mem[w_head_nxt];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/paillier_mont_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : paillier_mont_cmd_seq
// Description : Command sequencer in front of the Montgomery engine. Takes one
//               ME or MM command plus 2N operand words, drives the engine
//               load port, buffers the N result words and replays them as a
//               back-pressured stream.
// Revision    : 1.0 - initial release
// ============================================================================
module paillier_mont_cmd_seq
  import paillier_seq_pkg::*;
#(
  parameter int K = 256,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic [1:0]   cmd_mm_type,
  input  logic [K-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [K-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         busy,
  output logic         err_unexp,
  output logic         me_start,
  output logic [K-1:0] me_x,
  output logic         me_x_valid,
  output logic [K-1:0] me_y,
  output logic         me_y_valid,
  input  logic [K-1:0] me_result,
  input  logic         me_valid,
  output logic [1:0]   mm_type,
  output logic         mm_start,
  output logic [K-1:0] mm_x,
  output logic         mm_x_valid,
  output logic [K-1:0] mm_y,
  output logic         mm_y_valid,
  input  logic [K-1:0] mm_result,
  input  logic         mm_valid
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;

  seq_state_e    r_state;
  seq_state_e    w_state_nxt;
  logic          r_op;
  logic [1:0]    r_mm_type;
  logic [AW-1:0] r_wcnt;
  logic [CW-1:0] r_rcnt;
  logic          r_err;

  logic          w_xfer;
  logic          w_res_valid;
  logic [K-1:0]  w_res_data;
  logic          w_push;
  logic          w_pop;
  logic          w_done;
  logic          w_unexp;
  logic [AW-1:0] w_rd_idx;
  logic [CW-1:0] w_count;

  assign w_xfer      = s_valid && s_ready;
  assign w_res_valid = (r_op == OP_MM) ? mm_valid : me_valid;
  assign w_res_data  = (r_op == OP_MM) ? mm_result : me_result;
  // Only the selected path in WAIT_RES is captured; N words per command
  assign w_push      = (r_state == WAIT_RES) && w_res_valid && (r_rcnt != CW'(N));
  assign m_valid     = (w_count != '0);
  assign w_pop       = m_valid && m_ready;
  assign m_last      = m_valid && (w_rd_idx == AW'(N - 1));
  assign w_done      = w_pop && m_last && (r_rcnt == CW'(N));
  assign busy        = (r_state != IDLE);
  assign err_unexp   = r_err;
  // Any result valid that the current state/op does not expect
  assign w_unexp     = (me_valid && !((r_state == WAIT_RES) && (r_op == OP_ME))) ||
                       (mm_valid && !((r_state == WAIT_RES) && (r_op == OP_MM)));

  paillier_res_buf #(
    .K (K),
    .N (N)
  ) u_res_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_res_data),
    .pop       (w_pop),
    .rd_data   (m_data),
    .rd_idx    (w_rd_idx),
    .count     (w_count)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Command latch, word counters and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= OP_ME;
      r_mm_type <= 2'b00;
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_err     <= 1'b0;
    end else begin
      if ((r_state == IDLE) && cmd_valid) begin
        r_op      <= cmd_op;
        r_mm_type <= cmd_mm_type;
      end
      // N is a power of two, so the counter wraps to 0 after word N-1
      if (((r_state == LOAD_X) || (r_state == LOAD_Y)) && w_xfer) begin
        r_wcnt <= r_wcnt + AW'(1);
      end
      if (w_done)      r_rcnt <= '0;
      else if (w_push) r_rcnt <= r_rcnt + CW'(1);
      if (w_unexp) r_err <= 1'b1;
    end
  end

  // Next-state logic, start pulses and operand forwarding mux
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    s_ready     = 1'b0;
    me_start    = 1'b0;
    me_x        = '0;
    me_x_valid  = 1'b0;
    me_y        = '0;
    me_y_valid  = 1'b0;
    mm_start    = 1'b0;
    mm_x        = '0;
    mm_x_valid  = 1'b0;
    mm_y        = '0;
    mm_y_valid  = 1'b0;
    mm_type     = 2'b00;
    if ((r_state != IDLE) && (r_op == OP_MM)) begin
      mm_type = r_mm_type;
    end
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = START;
      end
      START: begin
        me_start    = (r_op == OP_ME);
        mm_start    = (r_op == OP_MM);
        w_state_nxt = LOAD_X;
      end
      LOAD_X: begin
        s_ready = 1'b1;
        if (r_op == OP_ME) begin
          me_x       = s_data;
          me_x_valid = s_valid;
        end else begin
          mm_x       = s_data;
          mm_x_valid = s_valid;
        end
        if (s_valid && (r_wcnt == AW'(N - 1))) w_state_nxt = LOAD_Y;
      end
      LOAD_Y: begin
        s_ready = 1'b1;
        if (r_op == OP_ME) begin
          me_y       = s_data;
          me_y_valid = s_valid;
        end else begin
          mm_y       = s_data;
          mm_y_valid = s_valid;
        end
        if (s_valid && (r_wcnt == AW'(N - 1))) w_state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (w_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire
